// File: rtl/seq_mult_4b_pkg.sv
// Shared constants for the 4x4 sequential shift-add multiplier.
package seq_mult_4b_pkg;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned ITER   = WIDTH;
  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = $clog2(ITER);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/seq_mult_4b_if.sv
// Request/result bundle between a multiply requester and seq_mult_4b.
interface seq_mult_4b_if;
  import seq_mult_4b_pkg::*;

  logic              start;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/seq_mult_4b_rcas_4b.sv
// 4-bit ripple-carry adder/subtractor: mode=0 adds, mode=1 subtracts (a - b).
module rcas_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       mode,
  output logic [3:0] res,
  output logic       cout
);

  logic [3:0] b_eff;
  logic [4:0] c;

  // Ripple the carry through four full-adder cells.
  always_comb begin
    b_eff = b ^ {4{mode}};
    c     = '0;
    res   = '0;
    c[0]  = mode;
    for (int i = 0; i < 4; i++) begin
      res[i]  = a[i] ^ b_eff[i] ^ c[i];
      c[i+1]  = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
    end
    cout = c[4];
  end

endmodule

// File: rtl/seq_mult_4b.sv
// Sequential unsigned 4x4 shift-add multiplier, one add-and-shift per cycle.
module seq_mult_4b
  import seq_mult_4b_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  seq_mult_4b_if.slave bus
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WIDTH-1:0]  m;
  logic [WIDTH-1:0]  m_nxt;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  acc_nxt;
  logic [WIDTH-1:0]  q;
  logic [WIDTH-1:0]  q_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [PROD_W-1:0] product_q;
  logic [PROD_W-1:0] product_nxt;
  logic              busy_q;
  logic              busy_nxt;
  logic              done_q;
  logic              done_nxt;
  logic              accept;

  logic [WIDTH-1:0]  add_b;
  logic [WIDTH-1:0]  add_res;
  logic              add_cout;

  // Partial product: add the multiplicand only when the current multiplier LSB is set.
  assign add_b = q[0] ? m : '0;

  rcas_4b u_add (
    .a    (acc),
    .b    (add_b),
    .mode (1'b0),
    .res  (add_res),
    .cout (add_cout)
  );

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

  // Next-state, datapath and output decode; the adder carry is absorbed into acc by the shift.
  always_comb begin
    state_nxt   = state;
    m_nxt       = m;
    acc_nxt     = acc;
    q_nxt       = q;
    cnt_nxt     = cnt;
    product_nxt = product_q;
    accept      = bus.start && ((state == ST_IDLE) || (state == ST_DONE));

    case (state)
      ST_IDLE: state_nxt = ST_IDLE;
      ST_CALC: begin
        acc_nxt = {add_cout, add_res[WIDTH-1:1]};
        q_nxt   = {add_res[0], q[WIDTH-1:1]};
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(ITER - 1)) begin
          state_nxt   = ST_DONE;
          product_nxt = {add_cout, add_res, q[WIDTH-1:1]};
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    if (accept) begin
      state_nxt = ST_CALC;
      m_nxt     = bus.a;
      q_nxt     = bus.b;
      acc_nxt   = '0;
      cnt_nxt   = '0;
    end

    busy_nxt = (state_nxt == ST_CALC);
    done_nxt = (state_nxt == ST_DONE);
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      m         <= '0;
      acc       <= '0;
      q         <= '0;
      cnt       <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      m         <= m_nxt;
      acc       <= acc_nxt;
      q         <= q_nxt;
      cnt       <= cnt_nxt;
      product_q <= product_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
    end
  end

endmodule

// File: doc/seq_mult_4b.md
Name: seq_mult_4b

Overview:
Sequential unsigned 4x4 shift-add multiplier producing an 8-bit product in 4 iteration cycles. Uses one rcas_4b instance, with mode tied to 0 (add), as its adder. It drives the adder's a/b operands each cycle and consumes its res/cout. It is the next arithmetic stage built on the 4-bit add/sub datapath.

Parameters:
- WIDTH, 4, operand width. Only 4 is supported because the rcas_4b adder is fixed at 4 bits.
- ITER, WIDTH, number of iteration cycles.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request to start a multiply; sampled on rising clk
- a  input  4  multiplicand; captured when start is accepted
- b  input  4  multiplier; captured when start is accepted
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when product becomes valid
- product  output  8  a*b unsigned; held until the next accepted start

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst is asynchronous and active-high.
  - On rst: state=IDLE, busy=0, done=0, product=8'h00, and all internal registers cleared (m, acc, q, carry, cnt).
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 at an edge: m<=a, q<=b, acc<=0, carry<=0, cnt<=0, next=CALC.
  - Otherwise stay in IDLE.
- CALC (busy=1):
  - Adder inputs: rcas_4b a=acc, b=(q[0] ? m : 4'b0000), mode=0.
  - Each edge: {carry,acc,q} <= {1'b0, cout, res, q} >> 1, i.e. acc <= {cout, res[3:1]} and q <= {res[0], q[3:1]}.
  - cnt increments each edge.
  - When cnt==ITER-1: next=DONE, and product <= the final {acc,q} value computed this edge.
- DONE (done=1, busy=0), lasts exactly one cycle:
  - start=1 at the DONE edge: accepted as in IDLE (back-to-back operation), next=CALC.
  - Otherwise next=IDLE.
- Latency:
  - start sampled at edge k.
  - busy high for cycles k+1..k+4.
  - done high for the cycle after edge k+4.
  - product valid from edge k+4 onwards.
  - Start-to-start throughput: 5 cycles.
- start while in CALC is ignored. Captured operands do not change, and a/b may change freely once start is accepted.
- product changes only at the edge entering DONE. It is held through IDLE and through the next CALC, and is never zeroed except by rst.
- Width rule: the 8-bit product never overflows (max 15*15=225=8'hE1). The adder carry is always absorbed into acc via the shift.
- Reset mid-CALC: immediate return to IDLE with outputs at reset values. No done pulse is issued for the aborted operation.
- start held high continuously: results in back-to-back operations, each with a one-cycle done.
- Outputs busy and done decode directly from registered state. No combinational path from start to outputs.

Decomposition:
- Shared package/header:
  - state encoding constants: ST_IDLE=2'b00, ST_CALC=2'b01, ST_DONE=2'b10
  - WIDTH=4 and ITER constants
  - PROD_W=2*WIDTH
- Sub-module: the existing rcas_4b (ports a, b, mode, res, cout), instantiated once with mode=1'b0.
- FSM, counter and shift registers live in seq_mult_4b itself. No further sub-modules.

Test Plan:
- Reset: assert rst for 3 cycles mid-simulation -> busy=0, done=0, product=8'h00 immediately (asynchronous, no clk edge needed).
- Basic operations, one start pulse each:
  - a=4'h0, b=4'h0 -> done after 5 cycles, product=8'h00.
  - a=4'h9, b=4'h6 -> product=8'h36.
  - a=4'h4, b=4'h9 -> product=8'h24.
- Max operands: a=4'hF, b=4'hF -> product=8'hE1.
- Timing: busy high for exactly 4 cycles, done high for exactly 1 cycle.
- Start while busy: start a=3, b=8, then pulse start with a=7, b=1 two cycles later -> single done, product=8'h18, no second operation.
- Back-to-back: start held high, first a=7, b=1 then a=5, b=5 presented on the DONE cycle -> first done with 8'h07, second done 5 cycles later with 8'h19.
- Reset mid-operation: start a=F, b=F, assert rst at cycle 2 of CALC -> IDLE, no done pulse, product=8'h00. Next start a=2, b=3 -> product=8'h06.
